fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data word width, matching the FIFO write-data width.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter MAX_BURST, default 8: maximum words per grant, range 1..256.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 CLK  in  1  clock; the FIFO write-side clock.
REQ-006 RST  in  1  asynchronous active-high reset.
REQ-007 REQ_VALID  in  NUM_REQ  per-requester word valid.
REQ-008 REQ_DATA  in  NUM_REQ*WIDTH  per-requester word; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 REQ_LAST  in  NUM_REQ  per-requester last-word-of-burst flag.
REQ-010 REQ_READY  out  NUM_REQ  per-requester word accepted this cycle.
REQ-011 FIFO_FULL  in  1  FIFO full flag, already in the CLK domain.
REQ-012 W_INC  out  1  FIFO write enable.
REQ-013 WR_DATA  out  WIDTH  FIFO write data.
REQ-014 GNT_ID  out  clog2(NUM_REQ)  index of the current or last grantee.
REQ-015 BUSY  out  1  high while in GRANT.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-017 In IDLE with any REQ_VALID high, the round-robin winner SHALL be chosen, searching from index (last_gnt+1) mod NUM_REQ upward; GNT_ID is registered and the FSM enters GRANT on the next edge.
REQ-018 In IDLE, REQ_READY, W_INC and BUSY SHALL be 0.
REQ-019 In GRANT, for grantee g: W_INC = REQ_VALID[g] & !FIFO_FULL; REQ_READY[g] = !FIFO_FULL; all other REQ_READY bits = 0; WR_DATA = REQ_DATA[g].
REQ-020 WR_DATA SHALL be a combinational mux, giving zero latency from the requester word to the FIFO write in GRANT.
REQ-021 A word is accepted when W_INC = 1; only accepted words SHALL increment the burst counter.
REQ-022 GRANT SHALL return to IDLE after an accepted word with REQ_LAST[g] = 1, after the MAX_BURST-th accepted word, or on any GRANT cycle with REQ_VALID[g] = 0.
REQ-023 FIFO_FULL high in GRANT SHALL stall the burst without releasing the grant, with no timeout.
REQ-024 One IDLE cycle SHALL separate consecutive grants; the arbitration latency is 1 cycle from IDLE.
REQ-025 last_gnt SHALL update on entry to GRANT, so that a requester that is continuously valid cannot win twice in a row while another requester is valid.
REQ-026 REQ_VALID and REQ_LAST of non-granted requesters SHALL be ignored.

Reset
REQ-027 RST high SHALL force, asynchronously: state=IDLE, burst count=0, GNT_ID=0, last_gnt=NUM_REQ-1 (requester 0 wins first), BUSY=0, W_INC=0, REQ_READY=0.
REQ-028 Reset mid-burst SHALL abort the burst; no W_INC may be issued in the cycle after RST deasserts.

Configuration
REQ-029 Macro FWA_STALL_CNT_EN.
- Defined: adds output STALL_CNT[15:0], a count of GRANT cycles with REQ_VALID[g] & FIFO_FULL; saturates at 16'hFFFF; reset to 0.
- Undefined: the port and its counter SHALL be absent.

Structure
REQ-030 Package fwa_pkg SHALL hold the state enum (IDLE, GRANT) and the default parameter constants.
REQ-031 Sub-module rr_arbiter SHALL be a combinational rotate-priority picker: inputs req and last_gnt, outputs the winner index and any_req.

Verification
REQ-032 Reset, then REQ_VALID=4'b0001 with REQ_LAST on word 3 -> GRANT after 1 cycle; words 0..3 written with W_INC=1 on 4 consecutive cycles; IDLE the cycle after.
REQ-033 All four requesters valid, 1-word bursts -> GNT_ID sequence 0,1,2,3,0 with an IDLE gap between grants.
REQ-034 MAX_BURST=8, requester 2 streams 20 words with no LAST -> bursts of 8, 8 and 4 words; another requester waiting is granted between bursts.
REQ-035 FIFO_FULL held high for 5 cycles mid-burst -> W_INC=0 and REQ_READY=0 for those 5 cycles, grant held, no word lost or duplicated; STALL_CNT=5 when FWA_STALL_CNT_EN is defined.
REQ-036 RST asserted on the 3rd word of a burst -> outputs 0 immediately; after release, a fresh arbitration starting from requester 0.
REQ-037 Granted requester drops REQ_VALID for 1 cycle -> grant released; the next valid requester in round-robin order is granted.

Source files
------------

// File: rtl/fwa_pkg.sv
// -----------------------------------------------------------------------------
// fwa_pkg
// Shared definitions for the FIFO write-side arbiter (fifo_wr_arbiter).
// Holds the arbiter FSM state enum and the default parameter values used by
// the top module and its round-robin picker.
// -----------------------------------------------------------------------------
package fwa_pkg;

    // Default configuration of fifo_wr_arbiter.
    localparam int FWA_WIDTH     = 8;   // FIFO write-data width
    localparam int FWA_NUM_REQ   = 4;   // number of requesters (2..8)
    localparam int FWA_MAX_BURST = 8;   // maximum words per grant (1..256)

    // Arbiter FSM: IDLE arbitrates, GRANT streams words from one requester.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } fwa_state_e;

endpackage : fwa_pkg

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotate-priority picker. The search starts at the index just
// after last_gnt and wraps modulo NUM_REQ; the first requesting index wins.
//
// Ports:
//   req       in   NUM_REQ  request vector
//   last_gnt  in   ID_W     index granted most recently
//   winner    out  ID_W     selected index (0 when no request is present)
//   any_req   out  1        at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = fwa_pkg::FWA_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_gnt,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    int            cand_s;
    logic [ID_W-1:0] cand_id_s;
    logic          found_s;

    // Walk the requesters in rotated order and keep the first one asserted.
    always_comb begin
        winner    = {ID_W{1'b0}};
        found_s   = 1'b0;
        cand_s    = 0;
        cand_id_s = {ID_W{1'b0}};
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = int'(last_gnt) + i;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_id_s = cand_s[ID_W-1:0];
            if (!found_s && req[cand_id_s]) begin
                winner  = cand_id_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_req = |req;
    end

endmodule : rr_arbiter

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share the write port of a
// single FIFO. A grant lasts for one burst: it ends after an accepted word
// flagged LAST, after MAX_BURST accepted words, or as soon as the grantee
// drops its valid. FIFO_FULL stalls a burst without releasing the grant.
// One IDLE cycle separates consecutive grants (arbitration happens in IDLE).
// The write path (WR_DATA, W_INC, REQ_READY) is combinational in GRANT so a
// presented word reaches the FIFO in the same cycle.
//
// Optional feature (macro FWA_STALL_CNT_EN): adds STALL_CNT[15:0], a
// saturating count of GRANT cycles where the grantee was valid but the FIFO
// was full.
//
// Ports:
//   CLK        in   1              FIFO write-side clock
//   RST        in   1              asynchronous active-high reset
//   REQ_VALID  in   NUM_REQ        per-requester word valid
//   REQ_DATA   in   NUM_REQ*WIDTH  per-requester word, requester i at [i*WIDTH +: WIDTH]
//   REQ_LAST   in   NUM_REQ        per-requester last-word-of-burst flag
//   REQ_READY  out  NUM_REQ        per-requester word accepted this cycle
//   FIFO_FULL  in   1              FIFO full flag (CLK domain)
//   W_INC      out  1              FIFO write enable
//   WR_DATA    out  WIDTH          FIFO write data
//   GNT_ID     out  clog2(NUM_REQ) index of the current or last grantee
//   BUSY       out  1              high while in GRANT
//   STALL_CNT  out  16             stall cycle count (FWA_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fwa_pkg::*;
#(
    parameter  int WIDTH     = FWA_WIDTH,
    parameter  int NUM_REQ   = FWA_NUM_REQ,
    parameter  int MAX_BURST = FWA_MAX_BURST,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]       REQ_LAST,
    output logic [NUM_REQ-1:0]       REQ_READY,
    input  logic                     FIFO_FULL,
    output logic                     W_INC,
    output logic [WIDTH-1:0]         WR_DATA,
    output logic [ID_W-1:0]          GNT_ID,
    output logic                     BUSY
`ifdef FWA_STALL_CNT_EN
    ,
    output logic [15:0]              STALL_CNT
`endif
);

    // Counter holds the number of words already accepted in this burst,
    // so the MAX_BURST-th word is the one accepted while it reads MAX_BURST-1.
    localparam int                CNT_W        = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_LAST   = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]   LAST_GNT_RST = ID_W'(NUM_REQ - 1);

    fwa_state_e       state_q, state_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [ID_W-1:0]  winner_s;
    logic             any_req_s;
    logic             gnt_valid_s;
    logic             gnt_last_s;
    logic [WIDTH-1:0] gnt_data_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req      (REQ_VALID),
        .last_gnt (last_gnt_q),
        .winner   (winner_s),
        .any_req  (any_req_s)
    );

    // Grantee's valid and last flags; other requesters are ignored.
    assign gnt_valid_s = REQ_VALID[gnt_id_q];
    assign gnt_last_s  = REQ_LAST[gnt_id_q];

    // Select the grantee's word from the packed data bus.
    always_comb begin
        gnt_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id_q == ID_W'(i)) begin
                gnt_data_s = REQ_DATA[i*WIDTH +: WIDTH];
            end else begin
                gnt_data_s = gnt_data_s;
            end
        end
    end

    // FSM next state, burst bookkeeping and combinational write-side outputs.
    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        REQ_READY   = {NUM_REQ{1'b0}};
        W_INC       = 1'b0;
        BUSY        = 1'b0;
        WR_DATA     = {WIDTH{1'b0}};
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    // last_gnt moves on entry so a continuously valid winner
                    // loses priority to any other valid requester next time.
                    state_d     = GRANT;
                    gnt_id_d    = winner_s;
                    last_gnt_d  = winner_s;
                    burst_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                BUSY                = 1'b1;
                WR_DATA             = gnt_data_s;
                W_INC               = gnt_valid_s & ~FIFO_FULL;
                REQ_READY[gnt_id_q] = ~FIFO_FULL;
                if (!gnt_valid_s) begin
                    state_d     = IDLE;
                    burst_cnt_d = {CNT_W{1'b0}};
                end else if (FIFO_FULL) begin
                    // Stall: hold grant and count until the FIFO drains.
                    state_d = GRANT;
                end else if (gnt_last_s || (burst_cnt_q == BURST_LAST)) begin
                    state_d     = IDLE;
                    burst_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d     = GRANT;
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, grant and burst registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            gnt_id_q    <= {ID_W{1'b0}};
            last_gnt_q  <= LAST_GNT_RST;
            burst_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign GNT_ID = gnt_id_q;

`ifdef FWA_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count GRANT cycles blocked by a full FIFO, saturating at all-ones.
    always_comb begin
        if ((state_q == GRANT) && gnt_valid_s && FIFO_FULL && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

endmodule : fifo_wr_arbiter
